// File: rtl/grant_display_pkg.sv
// rtl/grant_display_pkg.sv - shared types, segment constants and BCD split helper for grant_display
// Purpose: display symbol encoding plus the index-to-digits helper.
// Ports: none (package).

package grant_display_pkg;

  `include "seg_codes.vh"

  // Symbols the display can show; 0..9 map straight onto their digit value.
  typedef enum logic [3:0] {
    SYM_0     = 4'd0,
    SYM_1     = 4'd1,
    SYM_2     = 4'd2,
    SYM_3     = 4'd3,
    SYM_4     = 4'd4,
    SYM_5     = 4'd5,
    SYM_6     = 4'd6,
    SYM_7     = 4'd7,
    SYM_8     = 4'd8,
    SYM_9     = 4'd9,
    SYM_DASH  = 4'd10,
    SYM_E     = 4'd11,
    SYM_G     = 4'd12,
    SYM_BLANK = 4'd13
  } sym_e;

  localparam int GRANT_W = 24;

  // Splits an index 0..23 into {tens, ones} using only compares against 10 and 20.
  // The ones digit is computed on the low nibble: for 10..19 the mod-16 subtract of
  // 10 and for 20..23 the subtract of 4 (20 = 16 + 4) give the right result.
  function automatic logic [7:0] split_bcd(input logic [4:0] idx);
    logic [3:0] tens;
    logic [3:0] ones;
    if (idx >= 5'd20) begin
      tens = 4'd2;
      ones = idx[3:0] - 4'd4;
    end else if (idx >= 5'd10) begin
      tens = 4'd1;
      ones = idx[3:0] - 4'd10;
    end else begin
      tens = 4'd0;
      ones = idx[3:0];
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg_codes.vh
// rtl/seg_codes.vh - active-low seven-segment codes and digit-pointer width shared by display blocks
// Purpose: one place for the segment patterns so every display block lights the same glyphs.
// Bit 7 is dp, bits 6:0 are g,f,e,d,c,b,a; a 0 lights the segment.
// Included inside a package or module scope, so it only declares localparams.

localparam int         DIGIT_PTR_W    = 2;

localparam logic [7:0] SEG_CODE_0     = 8'hC0;
localparam logic [7:0] SEG_CODE_1     = 8'hF9;
localparam logic [7:0] SEG_CODE_2     = 8'hA4;
localparam logic [7:0] SEG_CODE_3     = 8'hB0;
localparam logic [7:0] SEG_CODE_4     = 8'h99;
localparam logic [7:0] SEG_CODE_5     = 8'h92;
localparam logic [7:0] SEG_CODE_6     = 8'h82;
localparam logic [7:0] SEG_CODE_7     = 8'hF8;
localparam logic [7:0] SEG_CODE_8     = 8'h80;
localparam logic [7:0] SEG_CODE_9     = 8'h90;
localparam logic [7:0] SEG_CODE_DASH  = 8'hBF;
localparam logic [7:0] SEG_CODE_E     = 8'h86;
localparam logic [7:0] SEG_CODE_G     = 8'hC2;
localparam logic [7:0] SEG_CODE_BLANK = 8'hFF;

// File: rtl/seg_encode.sv
// rtl/seg_encode.sv - combinational symbol to active-low seven-segment encoder
// Purpose: maps a 4-bit display symbol onto its segment pattern; dp is always off.
// Ports:
//   i_sym  - symbol code (sym_e encoding)
//   o_seg  - active-low segments, bit 7 dp, bits 6:0 g..a

module seg_encode
  import grant_display_pkg::*;
(
  input  logic [3:0] i_sym,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_CODE_BLANK;
    case (i_sym)
      SYM_0:     o_seg = SEG_CODE_0;
      SYM_1:     o_seg = SEG_CODE_1;
      SYM_2:     o_seg = SEG_CODE_2;
      SYM_3:     o_seg = SEG_CODE_3;
      SYM_4:     o_seg = SEG_CODE_4;
      SYM_5:     o_seg = SEG_CODE_5;
      SYM_6:     o_seg = SEG_CODE_6;
      SYM_7:     o_seg = SEG_CODE_7;
      SYM_8:     o_seg = SEG_CODE_8;
      SYM_9:     o_seg = SEG_CODE_9;
      SYM_DASH:  o_seg = SEG_CODE_DASH;
      SYM_E:     o_seg = SEG_CODE_E;
      SYM_G:     o_seg = SEG_CODE_G;
      default:   o_seg = SEG_CODE_BLANK;
    endcase
  end

endmodule

// File: rtl/grant_display.sv
// rtl/grant_display.sv - synchronizes a one-hot arbiter grant, decodes it and scans it onto four digits
// Purpose: shows "G _ tens ones" for a single grant, "- _ - -" for none, "E _ E E" for several.
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - synchronous active-high reset
//   grant        - 24-bit grant vector, asynchronous to clk
//   seg          - active-low segments, bit 7 dp (always off)
//   sel          - active-low digit select, sel[0] rightmost
//   grant_index  - index of the single granted bit, else 0
//   grant_valid  - exactly one grant bit set
//   grant_error  - two or more grant bits set

module grant_display
  import grant_display_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GRANT_W-1:0]   grant,
  output logic [7:0]           seg,
  output logic [3:0]           sel,
  output logic [4:0]           grant_index,
  output logic                 grant_valid,
  output logic                 grant_error
);

  logic [GRANT_W-1:0]     r_sync1;
  logic [GRANT_W-1:0]     r_sync2;
  logic [4:0]             r_grant_index;
  logic                   r_grant_valid;
  logic                   r_grant_error;
  logic [SCAN_BITS-1:0]   r_refresh;
  logic [DIGIT_PTR_W-1:0] r_digit_ptr;
  logic [7:0]             r_seg;
  logic [3:0]             r_sel;

  logic                   w_any;
  logic                   w_multi;
  logic [4:0]             w_idx;
  logic                   w_wrap;
  logic                   w_load;
  logic [7:0]             w_bcd;
  logic [3:0]             w_sym;
  logic [7:0]             w_seg_code;

  // Two-flop synchronizer for the switch-derived grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= grant;
      r_sync2 <= r_sync1;
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_any   = |r_sync2;
  assign w_multi = |(r_sync2 & (r_sync2 - GRANT_W'(1)));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < GRANT_W; i++) begin
      if (r_sync2[i]) w_idx = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_index <= '0;
      r_grant_valid <= 1'b0;
      r_grant_error <= 1'b0;
    end else begin
      r_grant_index <= (w_any && !w_multi) ? w_idx : 5'd0;
      r_grant_valid <= w_any && !w_multi;
      r_grant_error <= w_multi;
    end
  end

  // Refresh timing: the pointer steps on counter wrap, and the digit outputs load
  // on the following cycle (counter back at 0). That cycle is also the first one
  // after reset, so every digit, including the first, is held 2^SCAN_BITS clocks.
  assign w_wrap = (r_refresh == '1);
  assign w_load = (r_refresh == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh   <= '0;
      r_digit_ptr <= '0;
    end else begin
      r_refresh <= r_refresh + SCAN_BITS'(1);
      if (w_wrap) r_digit_ptr <= r_digit_ptr + DIGIT_PTR_W'(1);
    end
  end

  // Symbol for the digit being loaded, taken from the registered decode only.
  always_comb begin
    w_bcd = split_bcd(r_grant_index);
    w_sym = SYM_BLANK;
    case (r_digit_ptr)
      2'd0: w_sym = r_grant_valid ? w_bcd[3:0] : (r_grant_error ? SYM_E : SYM_DASH);
      2'd1: w_sym = r_grant_valid ? w_bcd[7:4] : (r_grant_error ? SYM_E : SYM_DASH);
      2'd2: w_sym = SYM_BLANK;
      default: w_sym = r_grant_valid ? SYM_G : (r_grant_error ? SYM_E : SYM_DASH);
    endcase
  end

  seg_encode u_seg_encode (
    .i_sym (w_sym),
    .o_seg (w_seg_code)
  );

  // seg and sel load together once per digit, so a digit never mixes old and new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_CODE_BLANK;
      r_sel <= 4'b1111;
    end else if (w_load) begin
      r_seg <= w_seg_code;
      r_sel <= ~(4'b0001 << r_digit_ptr);
    end
  end

  assign seg         = r_seg;
  assign sel         = r_sel;
  assign grant_index = r_grant_index;
  assign grant_valid = r_grant_valid;
  assign grant_error = r_grant_error;

endmodule

// File: doc/grant_display.md
GRANT_DISPLAY -- requirements
Module: grant_display

Interface
REQ-001 Parameter SCAN_BITS, default 16: the refresh counter width; the display advances one digit every 2^SCAN_BITS clocks.
REQ-002 Port clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port grant, input, 24: one-hot grant vector from the arbiter, asynchronous to clk (switch-derived).
REQ-005 Port seg, output, 8: segment drive, active-low; bit 7 is dp and bits 6:0 are g,f,e,d,c,b,a.
REQ-006 Port sel, output, 4: digit select, active-low; sel[0] is the rightmost digit.
REQ-007 Port grant_index, output, 5: binary index of the granted bit, 0..23.
REQ-008 Port grant_valid, output, 1: high when exactly one grant bit is set.
REQ-009 Port grant_error, output, 1: high when two or more grant bits are set.

Function
REQ-010 The block SHALL pass grant through a two-flop synchronizer before any decode.
REQ-011 Decode SHALL be registered, giving three cycles from a grant change to grant_index, grant_valid and grant_error.
REQ-012 For zero bits set: grant_valid=0, grant_error=0, grant_index=0.
REQ-013 For exactly one bit n set: grant_valid=1, grant_error=0, grant_index=n.
REQ-014 For two or more bits set: grant_valid=0, grant_error=1, grant_index=0.
REQ-015 grant_valid and grant_error SHALL never be high together.
REQ-016 The SCAN_BITS-wide refresh counter SHALL increment every cycle and wrap to 0.
REQ-017 The 2-bit digit pointer SHALL advance 0->1->2->3->0 on each counter wrap.
REQ-018 Exactly one sel bit SHALL be low outside reset; sel and seg SHALL be registered and change in the same cycle.
REQ-019 Digit contents (digit3..digit0) SHALL be:
- valid: 'G', blank, tens(index), ones(index);
- none: '-', blank, '-', '-';
- error: 'E', blank, 'E', 'E'.
REQ-020 The tens digit SHALL show '0' for indices 0..9 (leading zero kept).
REQ-021 Digits SHALL be formed from the registered decode, so a decode change appears on the next refresh of each digit; no digit SHALL show a mix of old and new data.
REQ-022 dp (seg[7]) SHALL always be 1 (off).
REQ-023 Codes, hex, active-low:
- digits 0-9: C0 F9 A4 B0 99 92 82 F8 80 90;
- '-' BF, 'E' 86, 'G' C2, blank FF.
REQ-024 Tens/ones SHALL come from a compare against 10 and 20 (index < 24); no general divider.

Reset
REQ-025 While rst=1, on each clock:
- synchronizer and decode registers clear;
- refresh counter and digit pointer = 0;
- seg=FF, sel=1111, grant_index=0, grant_valid=0, grant_error=0.
REQ-026 If rst asserts mid-scan, the next clock SHALL apply the reset values of REQ-025, with no completion of the current digit.
REQ-027 On the first clock after rst deasserts, sel=1110, and seg SHALL show the digit0 code from the cleared decode ('-', BF).

Structure
REQ-028 The segment code constants and the digit-pointer width SHALL live in a shared header, seg_codes.vh, reused by other display blocks.
REQ-029 One sub-module, seg_encode (4-bit symbol in, 8-bit active-low segments out, combinational), SHALL hold the REQ-023 table.
REQ-030 Total RTL SHALL be between 120 and 400 lines.

Verification (SCAN_BITS=2 unless stated)
REQ-031 Reset: hold rst for 3 clocks -> seg=FF, sel=1111, all status outputs 0; release -> sel=1110, seg=BF.
REQ-032 Single grant: grant=24'h000800 (bit 11) -> after 3 clocks grant_index=11 and grant_valid=1; over one full scan: digit0=F9, digit1=F9, digit2=FF, digit3=C2.
REQ-033 Boundaries:
- grant=24'h000001 -> index 0, digits 3..0 = C2, FF, C0, C0;
- grant=24'h800000 -> index 23, digits 1,0 = A4, B0.
REQ-034 Multiple grant: grant=24'h000011 -> grant_error=1, grant_valid=0; digits 3,1,0 = 86.
REQ-035 No grant: grant=0 -> digits 3,1,0 = BF; sel walks 1110, 1101, 1011, 0111, 1110, with each step exactly 4 clocks.
REQ-036 Mid-scan reset and latency: change grant from bit 5 to bit 17, assert rst one clock later -> REQ-025 values on the next clock; after release, the REQ-011 three-cycle latency is measured exactly.
